// File: rtl/csa_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_pkg
//  Purpose  : Shared definitions for the carry-save accumulator: FSM state
//             encoding and a ceil(log2) helper used to size the result and
//             the operand counter.
//  Config   : CSA_ACCUM_SAT_EN (used by csa_accum, not here)
//  Revision : 1.0 - initial release
// ============================================================================
package csa_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      DONE    = 2'd2
   } state_e;

   // Smallest r with 2**r >= v; evaluated at elaboration time only.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accum_if
//  Purpose  : Operand/result handshake bundle for csa_accum.
//  Signals  : in_valid/in_ready/in_data/in_last  - operand stream
//             out_valid/out_ready                - result handshake
//             out_full (ACC_W), out_r (WIDTH), ov - result payload
//  Modports : master (operand producer / result consumer), slave (csa_accum)
//  Revision : 1.0 - initial release
// ============================================================================
interface csa_accum_if
   import csa_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MAX_OPS = 8
);
   localparam int ACC_W = WIDTH + clog2(MAX_OPS);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_full;
   logic [WIDTH-1:0] out_r;
   logic             ov;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_full, out_r, ov
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_full, out_r, ov
   );

endinterface : csa_accum_if
`default_nettype wire

// File: rtl/csa_3to2.sv
`default_nettype none
// ============================================================================
//  Module   : csa_3to2
//  Purpose  : Bitwise full-adder array (3:2 compressor). Three W-bit vectors
//             in, a sum vector and an unshifted carry vector out, so that
//             i_a + i_b + i_c == o_sum + 2*o_carry.
//  Ports    : i_a, i_b, i_c (W) - addends
//             o_sum (W)         - per-bit XOR
//             o_carry (W)       - per-bit majority, weight 2**(bit+1)
//  Revision : 1.0 - initial release
// ============================================================================
module csa_3to2 #(
   parameter int W = 8
) (
   input  wire logic [W-1:0] i_a,
   input  wire logic [W-1:0] i_b,
   input  wire logic [W-1:0] i_c,
   output logic      [W-1:0] o_sum,
   output logic      [W-1:0] o_carry
);

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign o_sum[i]   = i_a[i] ^ i_b[i] ^ i_c[i];
      assign o_carry[i] = (i_a[i] & i_b[i]) | (i_a[i] & i_c[i]) | (i_b[i] & i_c[i]);
   end

endmodule : csa_3to2
`default_nettype wire

// File: rtl/csa_accum.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accum
//  Purpose  : Accumulates up to MAX_OPS unsigned WIDTH-bit operands in
//             carry-save form (one 3:2 compression per accepted operand, no
//             carry propagation), then resolves the sum with a single adder
//             in a one-cycle RESOLVE state and holds it in DONE until taken.
//  Ports    : clk, rst (sync, active-high)
//             bus (csa_accum_if.slave): in_valid/in_ready/in_data/in_last,
//             out_valid/out_ready/out_full/out_r/ov
//  Config   : CSA_ACCUM_SAT_EN - when defined, out_r saturates to all-ones
//             on overflow; otherwise out_r is the wrapped low WIDTH bits.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_accum
   import csa_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MAX_OPS = 8
) (
   input  wire logic    clk,
   input  wire logic    rst,
   csa_accum_if.slave   bus
);

   localparam int ACC_W = WIDTH + clog2(MAX_OPS);
   localparam int CNT_W = clog2(MAX_OPS);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] s_q, s_d;
   logic [ACC_W-1:0] c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] out_full_q, out_full_d;
   logic [WIDTH-1:0] out_r_q, out_r_d;
   logic             ov_q, ov_d;

   logic             w_in_ready;
   logic             w_out_valid;
   logic [ACC_W-1:0] w_c_shift;
   logic [ACC_W-1:0] w_in_ext;
   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] w_carry;
   logic [ACC_W-1:0] w_resolved;
   logic             w_resolved_ov;
   logic [WIDTH-1:0] w_resolved_r;
   logic             w_force_last;
   logic             w_unused_carry_msb;

   // Stored carries carry weight 2; the bit shifted out the top is always
   // zero because the exact total of MAX_OPS operands fits in ACC_W bits.
   assign w_c_shift          = {c_q[ACC_W-2:0], 1'b0};
   assign w_unused_carry_msb = c_q[ACC_W-1];
   assign w_in_ext           = {{(ACC_W-WIDTH){1'b0}}, bus.in_data};

   csa_3to2 #(
      .W (ACC_W)
   ) u_csa (
      .i_a     (s_q),
      .i_b     (w_c_shift),
      .i_c     (w_in_ext),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_resolved    = s_q + w_c_shift;
   assign w_resolved_ov = |w_resolved[ACC_W-1:WIDTH];

`ifdef CSA_ACCUM_SAT_EN
   assign w_resolved_r = w_resolved_ov ? {WIDTH{1'b1}} : w_resolved[WIDTH-1:0];
`else
   assign w_resolved_r = w_resolved[WIDTH-1:0];
`endif

   // The counter wraps to zero on the MAX_OPS-th accept, which is also the
   // accept that forces the move to RESOLVE.
   assign w_force_last = (cnt_q == CNT_W'(MAX_OPS - 1));

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      c_d         = c_q;
      cnt_d       = cnt_q;
      out_full_d  = out_full_q;
      out_r_d     = out_r_q;
      ov_d        = ov_q;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;

      case (state_q)
         ACCUM: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               s_d   = w_sum;
               c_d   = w_carry;
               cnt_d = cnt_q + 1'b1;
               if (bus.in_last || w_force_last) begin
                  state_d = RESOLVE;
               end
            end
         end
         RESOLVE: begin
            out_full_d = w_resolved;
            out_r_d    = w_resolved_r;
            ov_d       = w_resolved_ov;
            state_d    = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               s_d     = '0;
               c_d     = '0;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         s_q        <= '0;
         c_q        <= '0;
         cnt_q      <= '0;
         out_full_q <= '0;
         out_r_q    <= '0;
         ov_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         c_q        <= c_d;
         cnt_q      <= cnt_d;
         out_full_q <= out_full_d;
         out_r_q    <= out_r_d;
         ov_q       <= ov_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_full  = out_full_q;
   assign bus.out_r     = out_r_q;
   assign bus.ov        = ov_q;

endmodule : csa_accum
`default_nettype wire

// File: tb/tb_csa_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_accum
//  Purpose  : Directed self-checking bench for csa_accum (WIDTH=4,
//             MAX_OPS=8). Inputs change and outputs are sampled on the
//             falling clock edge.
//  Config   : CSA_ACCUM_SAT_EN selects the expected out_r on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_accum;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   csa_accum_if #(.WIDTH(4), .MAX_OPS(8)) bus ();

   csa_accum #(
      .WIDTH   (4),
      .MAX_OPS (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected out_r for an overflowing result whose wrapped low bits are w.
   function automatic logic [3:0] exp_r_ov(input logic [3:0] w);
`ifdef CSA_ACCUM_SAT_EN
      return 4'hF;
`else
      return w;
`endif
   endfunction

   // Present one operand for one cycle (called at a falling edge while
   // in_ready is high), then park the inputs at junk values with
   // in_valid low so ignored data/last would be noticed.
   task automatic drive(input logic [3:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 4'hF;
      bus.in_last  = 1'b1;
   endtask

   // Called right after the last drive(): one cycle of RESOLVE (no valid),
   // then DONE with the expected payload.
   task automatic expect_result(input string name, input logic [6:0] full,
                                input logic [3:0] r, input logic o);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_lat_n1 out_valid got %b exp 0", name, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_lat_n2 out_valid/in_ready got %b/%b exp 1/0", name, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_full !== full || bus.out_r !== r || bus.ov !== o) begin
         errors++;
         $display("FAIL %s_data full/r/ov got %0d/%0d/%b exp %0d/%0d/%b",
                  name, bus.out_full, bus.out_r, bus.ov, full, r, o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs in_ready/out_valid got %b/%b exp 1/0", bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out_full !== 7'd0 || bus.out_r !== 4'd0 || bus.ov !== 1'b0) begin
         errors++;
         $display("FAIL reset_data full/r/ov got %0d/%0d/%b exp 0/0/0", bus.out_full, bus.out_r, bus.ov);
      end
   endtask

   task automatic test_basic();
      drive(4'd1, 1'b0);
      drive(4'd5, 1'b0);
      drive(4'd5, 1'b1);
      expect_result("basic", 7'd11, 4'd11, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_return in_ready/out_valid got %b/%b exp 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_overflow();
      drive(4'd15, 1'b0);
      drive(4'd5, 1'b0);
      drive(4'd2, 1'b1);
      expect_result("ovf", 7'd22, exp_r_ov(4'd6), 1'b1);
      @(negedge clk);
   endtask

   task automatic test_forced_last();
      for (int i = 0; i < 8; i++) begin
         drive(4'd15, 1'b0);
      end
      // Offer a 9th operand while the block is busy.
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd1;
      bus.in_last  = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL forced_resolve in_ready/out_valid got %b/%b exp 0/0", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL forced_done out_valid/in_ready got %b/%b exp 1/0", bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_full !== 7'd120 || bus.out_r !== exp_r_ov(4'd8) || bus.ov !== 1'b1) begin
         errors++;
         $display("FAIL forced_data full/r/ov got %0d/%0d/%b exp 120/%0d/1",
                  bus.out_full, bus.out_r, bus.ov, exp_r_ov(4'd8));
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(4'd7, 1'b0);
      drive(4'd6, 1'b0);
      drive(4'd8, 1'b1);
      expect_result("bp", 7'd21, exp_r_ov(4'd5), 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_full !== 7'd21) begin
            errors++;
            $display("FAIL bp_hold%0d valid/ready/full got %b/%b/%0d exp 1/0/21",
                     i, bus.out_valid, bus.in_ready, bus.out_full);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release out_valid/in_ready got %b/%b exp 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_abort();
      drive(4'd12, 1'b0);
      drive(4'd6, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_full !== 7'd0) begin
         errors++;
         $display("FAIL abort_state ready/valid/full got %b/%b/%0d exp 1/0/0",
                  bus.in_ready, bus.out_valid, bus.out_full);
      end
      drive(4'd11, 1'b1);
      expect_result("abort", 7'd11, 4'd11, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_zero();
      drive(4'd0, 1'b1);
      expect_result("zero", 7'd0, 4'd0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [3];
      ops[0] = 4'd3;
      ops[1] = 4'd9;
      ops[2] = 4'd14;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready%0d in_ready got %b exp 1", i, bus.in_ready);
         end
         drive(ops[i], 1'b1);
         expect_result("b2b", {3'd0, ops[i]}, ops[i], 1'b0);
         @(negedge clk);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 4'd0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overflow();
      test_forced_last();
      test_backpressure();
      test_reset_abort();
      test_zero();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_csa_accum
`default_nettype wire

// File: doc/csa_accum.md
CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits.
REQ-002 Parameter MAX_OPS, default 8: maximum operands per accumulation; power of two, at least 2.
REQ-003 Derived constant ACC_W = WIDTH + log2(MAX_OPS): full result width.
REQ-004 The clock port SHALL be clk, input, 1 bit; all logic SHALL be on its rising edge.
REQ-005 The reset port SHALL be rst, input, 1 bit; reset SHALL be synchronous and active-high.
REQ-006 in_valid  input  1  operand present.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 in_last  input  1  the operand is the final one of the accumulation.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_full  output  ACC_W  exact unsigned sum.
REQ-013 out_r  output  WIDTH  low result bits; saturated when CSA_ACCUM_SAT_EN is defined.
REQ-014 ov  output  1  the sum does not fit in WIDTH bits.

Function
REQ-015 The FSM SHALL have three states: ACCUM, RESOLVE and DONE; the reset state is ACCUM.
REQ-016 In ACCUM: in_ready=1 and out_valid=0; an operand is accepted when in_valid&&in_ready.
REQ-017 On each accept: (s,c) <= 3:2 compress(s, c<<1, in_data zero-extended to ACC_W); no carry propagation in ACCUM.
REQ-018 The operand counter increments on each accept; an accept with in_last=1 SHALL go to RESOLVE.
REQ-019 The MAX_OPS-th accept SHALL go to RESOLVE even when in_last=0 (forced last).
REQ-020 RESOLVE SHALL last exactly one cycle: out_full <= s + (c<<1) truncated to ACC_W; then go to DONE; in_ready=0.
REQ-021 Latency: last accept at cycle N -> out_valid=1 from cycle N+2.
REQ-022 In DONE: out_valid=1 and in_ready=0; out_full, out_r and ov SHALL stay stable until out_valid&&out_ready.
REQ-023 On the DONE handshake: clear s, c and the counter; return to ACCUM. in_ready rises the next cycle, so there is no same-cycle accept.
REQ-024 ov = (out_full[ACC_W-1:WIDTH] != 0), registered with out_full.
REQ-025 Without the macro, out_r = out_full[WIDTH-1:0].
REQ-026 Back-to-back single-operand groups (in_last=1 on each) SHALL give one result per 3 cycles under out_ready=1.
REQ-027 in_data and in_last SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-028 On rst=1 at a clock edge the block SHALL go to ACCUM, and s, c, counter, out_full, out_r and ov SHALL become 0.
REQ-029 After reset, in_ready=1 and out_valid=0.
REQ-030 Reset in any state SHALL abort the current accumulation with no partial result output.

Configuration
REQ-031 Macro CSA_ACCUM_SAT_EN defined: out_r = all-ones when ov=1, otherwise the low bits.
REQ-032 Macro CSA_ACCUM_SAT_EN undefined: out_r is the wrapped low bits; ov is identical in both builds.

Structure
REQ-033 Package csa_pkg SHALL hold the FSM state encoding (ACCUM=0, RESOLVE=1, DONE=2) and the clog2 function used for ACC_W and the counter width.
REQ-034 Sub-module csa_3to2 (parameter W): bitwise full-adder array giving sum and carry vectors; one instance of width ACC_W.

Verification (WIDTH=4, MAX_OPS=8)
REQ-035 Operands 1, 5, 5 (last on 5), out_ready=1 -> out_full=11, out_r=11, ov=0, out_valid 2 cycles after the last accept.
REQ-036 Operands 15, 5, 2 -> out_full=22, ov=1; out_r=6 without the macro, 15 with CSA_ACCUM_SAT_EN.
REQ-037 Eight operands of 15, in_last never set -> forced last on the 8th; out_full=120, ov=1; a 9th offered operand waits (in_ready=0).
REQ-038 Operands 7, 6, 8 with out_ready=0 for 5 cycles -> out_valid held, out_full=21 stable, in_ready=0; accepted when out_ready=1, in_ready=1 the next cycle.
REQ-039 Operands 12, 6, then rst=1 for one cycle, then 11 with last -> out_full=11, ov=0.
REQ-040 A single operand 0 with last -> out_full=0, ov=0, out_valid at cycle N+2.
